// File: rtl/capture_ctrl.sv
// Acquisition sequencer: arms on command, triggers on a channel A level/slope
// crossing (or timeout), writes a fixed-length word burst to the FIFO, then waits for drain.
module capture_ctrl #(
  parameter int CNT_W        = 10,
  parameter int AUTO_TIMEOUT = 1000000,
  parameter int AUTO_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             mode_cont_i,
  input  logic             mode_auto_i,
  input  logic             trig_slope_i,
  input  logic [13:0]      trig_level_i,
  input  logic [CNT_W-1:0] capture_len_i,
  input  logic             adc_valid_i,
  input  logic [31:0]      adc_data_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  output logic             fifo_wr_en_o,
  output logic [31:0]      fifo_din_o,
  output logic             busy_o,
  output logic             armed_o,
  output logic             trig_forced_o,
  output logic             overflow_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [13:0]        level_q, level_d;
  logic               slope_q, slope_d;
  logic [13:0]        prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
  logic [CNT_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]         wait_q, wait_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        din_q, din_d;
  logic               forced_q, forced_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [13:0]    cur;
  logic           trig_hit;
  logic [CNT_W:0] target;
  logic [CNT_W:0] word_inc;
  logic           take_word;
  logic           do_arm;

  assign cur      = adc_data_i[13:0];
  assign trig_hit = prev_valid_q && (slope_q ? (prev_q > level_q && cur <= level_q)
                                             : (prev_q < level_q && cur >= level_q));
  // A latched length of zero means the full 2^CNT_W window.
  assign target   = (len_q == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len_q};
  assign word_inc = word_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    len_d        = len_q;
    level_d      = level_q;
    slope_d      = slope_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    auto_cnt_d   = auto_cnt_q;
    word_cnt_d   = word_cnt_q;
    wait_d       = wait_q;
    wr_en_d      = 1'b0;
    din_d        = din_q;
    forced_d     = forced_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    take_word    = 1'b0;
    do_arm       = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (arm_i) do_arm = 1'b1;
        S_ARMED: begin
          auto_cnt_d = auto_cnt_q + 1'b1;
          if (adc_valid_i) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
          end
          if (adc_valid_i && trig_hit) begin
            take_word  = 1'b1;
            word_cnt_d = (CNT_W+1)'(1);
            wait_d     = '0;
            state_d    = (target == (CNT_W+1)'(1)) ? S_DRAIN : S_CAPTURE;
          end else if (mode_auto_i && auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1)) begin
            word_cnt_d = '0;
            forced_d   = 1'b1;
            state_d    = S_CAPTURE;
          end
        end
        S_CAPTURE: if (adc_valid_i) begin
          take_word  = 1'b1;
          word_cnt_d = word_inc;
          if (word_inc == target) begin
            wait_d  = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Hold off sampling fifo_empty until the last write's flag update has settled.
          if (wait_q != 2'd2) begin
            wait_d = wait_q + 1'b1;
          end else if (fifo_empty_i) begin
            done_d = 1'b1;
            if (mode_cont_i) do_arm = 1'b1;
            else             state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (take_word) begin
      if (!fifo_full_i) begin
        wr_en_d = 1'b1;
        din_d   = adc_data_i;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (do_arm) begin
      state_d      = S_ARMED;
      len_d        = capture_len_i;
      level_d      = trig_level_i;
      slope_d      = trig_slope_i;
      ovf_d        = 1'b0;
      forced_d     = 1'b0;
      auto_cnt_d   = '0;
      prev_valid_d = 1'b0;
    end
  end

  // NOTE: settings and data registers are reset too, so every output is defined out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      level_q      <= '0;
      slope_q      <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      auto_cnt_q   <= '0;
      word_cnt_q   <= '0;
      wait_q       <= '0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      forced_q     <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q      <= state_d;
      len_q        <= len_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      auto_cnt_q   <= auto_cnt_d;
      word_cnt_q   <= word_cnt_d;
      wait_q       <= wait_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      forced_q     <= forced_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign fifo_wr_en_o  = wr_en_q;
  assign fifo_din_o    = din_q;
  assign busy_o        = (state_q != S_IDLE);
  assign armed_o       = (state_q == S_ARMED);
  assign trig_forced_o = forced_q;
  assign overflow_o    = ovf_q;
  assign done_o        = done_q;

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Acquisition sequencer between the ADC sample stream and the sample FIFO.
- Arms on command and detects a level/slope trigger on channel A.
- Writes a programmable number of packed 32-bit sample words into the FIFO.
- Holds off further capture until the FIFO drains to the UART byte splitter, then returns to idle or re-arms (continuous mode).

Parameters:
- CNT_W, 10, width of capture length counter; max capture 2^CNT_W words
- AUTO_TIMEOUT, 1000000, ARMED cycles without trigger before forced trigger in auto mode
- AUTO_W, 20, width of auto timeout counter; must hold AUTO_TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  start request; level-sampled, acted on only in IDLE
- abort  in  1  return to IDLE from any state
- mode_cont  in  1  1 = re-arm automatically after drain
- mode_auto  in  1  1 = forced trigger after AUTO_TIMEOUT
- trig_slope  in  1  0 = rising, 1 = falling
- trig_level  in  14  unsigned trigger threshold
- capture_len  in  CNT_W  words per capture; 0 = 2^CNT_W
- adc_valid  in  1  one-cycle strobe, adc_data valid
- adc_data  in  32  packed word: ch A [13:0], ch B [29:16], others junk
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  32  FIFO write data
- busy  out  1  state != IDLE
- armed  out  1  state == ARMED
- trig_forced  out  1  last capture started by timeout; sticky until next arm
- overflow  out  1  sample dropped on full FIFO; sticky, cleared on arm
- done  out  1  one-cycle pulse when a capture has fully drained

Behaviour:
- Reset: state IDLE; every output 0; counters 0; prev-sample-valid flag 0.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE -> ARMED on arm=1:
  - Latch capture_len, trig_level, trig_slope.
  - Clear overflow, trig_forced, auto counter, prev-valid flag.
- ARMED:
  - On each adc_valid, store ch A as prev and set prev-valid.
  - Trigger is evaluated only when prev-valid=1 (first sample after arming never triggers).
  - Rising: prev < level AND cur >= level. Falling: prev > level AND cur <= level. All compares unsigned 14-bit.
  - On trigger, the triggering word is the first captured word: written in this same cycle's registered output, and the word counter is set to 1.
  - Auto timeout: counter increments every cycle in ARMED. When mode_auto=1 and count reaches AUTO_TIMEOUT-1:
    - Go to CAPTURE with word counter 0; set trig_forced.
    - Capture begins with the next adc_valid.
    - If a real trigger occurs in the same cycle, the real trigger wins.
- CAPTURE:
  - Each adc_valid advances the word counter.
  - Word is written if fifo_full=0; otherwise dropped and overflow set.
  - Dropped words still count (fixed time window).
  - After the word that makes count == latched length (0 -> 2^CNT_W), go to DRAIN.
- Write timing: fifo_wr_en and fifo_din are registered. Asserted the cycle after the edge that sampled adc_valid=1 with fifo_full=0, for exactly one cycle per word.
- DRAIN:
  - No writes.
  - Wait for fifo_empty=1; then pulse done for one cycle.
  - Next state is ARMED if mode_cont=1 (re-latch settings, clear sticky flags, as on arm), else IDLE.
  - fifo_empty is sampled only after the last write has retired: at least 2 cycles after DRAIN entry, to cover FIFO flag latency.
- Abort:
  - Highest priority, any state -> IDLE next edge.
  - fifo_wr_en 0 from the next edge; a write already registered is still completed.
  - done is not pulsed.
  - abort and arm in the same cycle: abort wins, stay IDLE.
- arm in a non-IDLE state is ignored.
- Settings inputs are ignored after latching; mid-capture changes have no effect.
- Reset mid-capture: immediate return to reset values. FIFO contents are not this block's concern.

Test Plan:
- Arm, rising, level=0x0800, capture_len=4; ch A sequence 0x0700, 0x07FF, 0x0801, 0x0900, 0x0A00, 0x0B00 -> writes of the words holding 0x0801, 0x0900, 0x0A00, 0x0B00; then DRAIN; done pulses once after fifo_empty; state IDLE.
- Falling, level=0x0100; first sample after arm 0x0050 (below level) -> no trigger on it; next 0x0200 then 0x0100 -> triggers on 0x0100.
- mode_auto=1, AUTO_TIMEOUT=16, flat ch A=0x0000, level=0x0800, capture_len=2 -> forced at cycle 16 of ARMED, trig_forced=1; next two adc_valid words written.
- capture_len=3, fifo_full held high during the second word -> 2 writes total, overflow=1, DRAIN entered after the third sample; next arm clears overflow.
- mode_cont=1, capture_len=2 -> after drain, done pulse then armed=1 without arm; abort during CAPTURE -> IDLE next cycle, no further fifo_wr_en, no done.
- capture_len=0, CNT_W=4 -> exactly 16 words written; rst asserted mid-capture -> all outputs 0 asynchronously.
